// File: rtl/fetch_avalon_master.sv
// -----------------------------------------------------------------------------
// fetch_avalon_master
//
// Instruction-fetch master for the fetch block RAM's Avalon-MM port. The RAM
// has a fixed one-cycle read latency and no waitrequest. Sequential word reads
// are issued from a running PC. Returned words are tagged with their PC and
// buffered in a small FIFO. Decode consumes them through a valid/ready
// handshake. A redirect flushes everything and restarts fetch at a new PC.
//
// Ports
//   clk             system clock
//   reset           asynchronous active-high reset
//   fetch_enable    allows new reads to be issued (IDLE <-> RUN)
//   redirect_valid  one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     new byte PC (bits [1:0] ignored)
//   inst_valid      FIFO head valid
//   inst_data       head instruction word
//   inst_pc         byte PC of head instruction
//   inst_ready      decode accepts the head this cycle
//   avm_*           Avalon-MM read master towards the fetch RAM
// -----------------------------------------------------------------------------
module fetch_avalon_master #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_enable,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  inst_valid,
   output logic [31:0]           inst_data,
   output logic [31:0]           inst_pc,
   input  logic                  inst_ready,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_chipselect,
   output logic                  avm_write,
   output logic [3:0]            avm_byteenable,
   output logic                  avm_clken,
   input  logic [31:0]           avm_readdata
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q;
   logic [31:0]     pc_q;
   logic [31:0]     pend_pc_q;
   logic            inflight_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;

   // Instruction buffer storage (data word and its byte PC per entry).
   logic [31:0]     data_mem [FIFO_DEPTH];
   logic [31:0]     pc_mem   [FIFO_DEPTH];

   logic [CW:0]     occupancy;
   logic            issue;
   logic            push;
   logic            pop;

   // Credit check uses registered count and inflight only, so a pop in the
   // current cycle does not free a slot until the next cycle.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue     = (state_q == ST_RUN) && !redirect_valid &&
                      (occupancy < (CW+1)'(FIFO_DEPTH));

   // A response is only meaningful when a read was issued last cycle and no
   // redirect is discarding it now.
   assign push = inflight_q && !redirect_valid;

   assign inst_valid = (count_q != '0);
   assign pop        = inst_valid && inst_ready && !redirect_valid;

   assign inst_data = data_mem[rd_ptr_q];
   assign inst_pc   = pc_mem[rd_ptr_q];

   assign avm_address    = pc_q[ADDR_WIDTH+1:2];
   assign avm_chipselect = issue;
   assign avm_write      = 1'b0;
   assign avm_byteenable = 4'hF;
   assign avm_clken      = 1'b1;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state: FSM, PC, in-flight tracking and FIFO pointers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC_ALIGNED;
         pend_pc_q  <= RESET_PC_ALIGNED;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else if (redirect_valid) begin
         // Redirect wins over everything and holds the current state.
         pc_q       <= redirect_pc & 32'hFFFF_FFFC;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= fetch_enable ? ST_RUN : ST_IDLE;
         inflight_q <= issue;
         if (issue) begin
            pend_pc_q <= pc_q;
            pc_q      <= pc_q + 32'd4;
         end
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Buffer contents need no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= avm_readdata;
         pc_mem[wr_ptr_q]   <= pend_pc_q;
      end
   end

   // The credit rule must make a push into a full buffer impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_avalon_master.sv
// -----------------------------------------------------------------------------
// tb_fetch_avalon_master
//
// Self-checking bench for fetch_avalon_master. A behavioural RAM answers reads
// one cycle after chipselect with word k = 32'h1000_0000 + k. A queue-based
// reference model predicts the chipselect, address, head valid, head PC and
// head data every cycle. The expected data is derived from the predicted PC.
// Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_fetch_avalon_master;

   localparam int AW    = 10;
   localparam int DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fetch_enable = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = 32'h0;
   logic          inst_valid;
   logic [31:0]   inst_data;
   logic [31:0]   inst_pc;
   logic          inst_ready = 1'b0;
   logic [AW-1:0] avm_address;
   logic          avm_chipselect;
   logic          avm_write;
   logic [3:0]    avm_byteenable;
   logic          avm_clken;
   logic [31:0]   avm_readdata = 32'h0;

   fetch_avalon_master #(
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_enable   (fetch_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write      (avm_write),
      .avm_byteenable (avm_byteenable),
      .avm_clken      (avm_clken),
      .avm_readdata   (avm_readdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: buffered PCs, one pending read, running PC, run flag.
   logic [31:0] m_q[$];
   bit          m_run;
   bit          m_inflight;
   logic [31:0] m_pc;
   logic [31:0] m_pend;

   // RAM-side bookkeeping: what the DUT requested last cycle.
   bit          prev_cs;
   logic [AW-1:0] prev_addr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
      return 32'h1000_0000 + 32'(a);
   endfunction

   function automatic logic [31:0] word_of_pc(input logic [31:0] pc);
      logic [AW-1:0] a;
      a = pc[AW+1:2];
      return ram_word(a);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_run      = 1'b0;
      m_inflight = 1'b0;
      m_pc       = RST_PC & 32'hFFFF_FFFC;
      m_pend     = 32'h0;
      prev_cs    = 1'b0;
      prev_addr  = '0;
   endtask

   // Called 1 time unit after a rising edge. Asserts reset mid-cycle, checks
   // the outputs drop before the next edge, holds for two edges, releases.
   task automatic do_reset();
      #2;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      #1;
      check_eq("rst_inst_valid", 32'(inst_valid), 32'h0);
      check_eq("rst_chipselect", 32'(avm_chipselect), 32'h0);
      check_eq("avm_write", 32'(avm_write), 32'h0);
      check_eq("avm_byteenable", 32'(avm_byteenable), 32'hF);
      check_eq("avm_clken", 32'(avm_clken), 32'h1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      $display("reset released, pc restarts at %h", m_pc);
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance
   // the model across the closing edge. Entered and left 1 unit after an edge.
   task automatic step(input bit fe, input bit rv, input logic [31:0] rpc,
                       input bit rdy, input bit verbose);
      bit          e_cs;
      bit          e_valid;
      logic [31:0] e_pc;
      avm_readdata   = prev_cs ? ram_word(prev_addr) : $urandom;
      fetch_enable   = fe;
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      #1;
      e_cs    = m_run && !rv && ((m_q.size() + int'(m_inflight)) < DEPTH);
      e_valid = (m_q.size() != 0);
      check_eq("chipselect", 32'(avm_chipselect), 32'(e_cs));
      if (e_cs) check_eq("address", 32'(avm_address), 32'(m_pc[AW+1:2]));
      check_eq("inst_valid", 32'(inst_valid), 32'(e_valid));
      if (e_valid) begin
         e_pc = m_q[0];
         check_eq("inst_pc", inst_pc, e_pc);
         check_eq("inst_data", inst_data, word_of_pc(e_pc));
         if (verbose && rdy && !rv)
            $display("deliver pc=%h data=%h", inst_pc, inst_data);
      end
      if (verbose && rv) $display("redirect to %h", rpc);
      prev_cs   = avm_chipselect;
      prev_addr = avm_address;
      if (rv) begin
         m_q.delete();
         m_inflight = 1'b0;
         m_pc       = rpc & 32'hFFFF_FFFC;
      end else begin
         if (e_valid && rdy) void'(m_q.pop_front());
         if (m_inflight) m_q.push_back(m_pend);
         if (e_cs) begin
            m_pend = m_pc;
            m_pc   = m_pc + 32'd4;
         end
         m_inflight = e_cs;
         m_run      = fe;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      // Power-on reset (entered at t=0, same sequence as a mid-stream reset).
      do_reset();

      // Streaming from RESET_PC with decode always ready.
      repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // Back-pressure: buffer fills, issue stops, then resumes.
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // Partially filled buffer plus a read in flight, then redirect.
      repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
      repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // Address wrap at the top of the RAM.
      step(1'b1, 1'b1, 32'h0000_0FFC, 1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // fetch_enable dropped mid-stream, then restored.
      repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // 32-bit PC wrap.
      step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // Asynchronous reset mid-stream.
      do_reset();
      repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit          fe;
         bit          rv;
         bit          rdy;
         logic [31:0] rpc;
         fe  = ($urandom_range(0, 9) != 0);
         rv  = ($urandom_range(0, 29) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         rpc = ($urandom_range(0, 1) == 0) ? $urandom
                                           : (32'h0000_0FF0 + 32'($urandom_range(0, 15)));
         if ($urandom_range(0, 599) == 0) do_reset();
         else step(fe, rv, rpc, rdy, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
